// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Tag entries carry a fixed-width destination field; register addresses
// up to TAG_AW bits wide are zero-extended into it.
package hazard_forward_unit_pkg;

   // Widest register address the tag entries can hold.
   localparam int TAG_AW = 8;

   // Operand select value meaning "read the register file".
   localparam int SEL_RF = 0;

   // One tracked post-EX pipeline stage.
   typedef struct packed {
      logic              valid;    // stage holds a real register write
      logic [TAG_AW-1:0] dest;     // destination register
      logic              is_load;  // result comes from data memory
   } tag_t;

endpackage

// File: rtl/hazard_tag_pipe.sv
// Freezable shift register of destination tags, one entry per post-EX stage.
// Latency: entry 1 loads one edge after the EX tag is presented.
// Backpressure: freeze_i holds every entry; reset_i clears them all to invalid.
module hazard_tag_pipe
   import hazard_forward_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   freeze_i,
   input  tag_t                   tag_i,
   output tag_t [DEPTH-1:0]       tags_o
);

   tag_t [DEPTH-1:0] tags_q;
   tag_t [DEPTH-1:0] tags_d;

   // Next state: shift towards older stages unless the pipeline is frozen.
   always_comb begin
      tags_d = tags_q;
      if (!freeze_i) begin
         tags_d[0] = tag_i;
         for (int k = 1; k < DEPTH; k++) begin
            tags_d[k] = tags_q[k-1];
         end
      end
   end

   // Tag registers with synchronous reset to invalid.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tags_q <= '0;
      end else begin
         tags_q <= tags_d;
      end
   end

   assign tags_o = tags_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding select, load-use stall and memory-wait freeze generation.
// Latency: all outputs combinational from inputs and the registered tag pipe.
// Backpressure: freeze_o holds every pipeline register (and the tags); it
// dominates stall_o. Optional HAZ_PERF_CNT_EN adds saturating event counters.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   localparam int SEL_W  = $clog2(DEPTH+1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       ex_reg_write_i,
   input  logic                       ex_mem_read_i,
   input  logic [REG_AW-1:0]          ex_dest_i,
   input  logic [NUM_SRC*REG_AW-1:0]  ex_src_i,
   input  logic                       id_valid_i,
   input  logic [NUM_SRC*REG_AW-1:0]  id_src_i,
   input  logic                       mem_ready_i,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
   output logic                       stall_o,
`ifdef HAZ_PERF_CNT_EN
   output logic [31:0]                stall_cnt_o,
   output logic [31:0]                freeze_cnt_o,
`endif
   output logic                       freeze_o
);

   tag_t             ex_tag;
   tag_t [DEPTH-1:0] tags;
   logic             load_use;

   // Tag for the instruction leaving EX; writes to r0 are never tracked.
   always_comb begin
      ex_tag         = '0;
      ex_tag.valid   = ex_reg_write_i && (ex_dest_i != '0);
      ex_tag.dest    = TAG_AW'(ex_dest_i);
      ex_tag.is_load = ex_mem_read_i;
   end

   hazard_tag_pipe #(
      .DEPTH    (DEPTH)
   ) u_tag_pipe (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .freeze_i (freeze_o),
      .tag_i    (ex_tag),
      .tags_o   (tags)
   );

   // Per-channel forward select: scan oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_sel_o = '0;
      for (int n = 0; n < NUM_SRC; n++) begin
         fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(SEL_RF);
         for (int k = DEPTH; k >= 1; k--) begin
            if (tags[k-1].valid && (tags[k-1].dest == TAG_AW'(ex_src_i[n*REG_AW +: REG_AW]))) begin
               fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(k);
            end
         end
      end
   end

   // Load in EX whose result is needed by the instruction in ID.
   always_comb begin
      load_use = 1'b0;
      if (id_valid_i && ex_mem_read_i && ex_reg_write_i && (ex_dest_i != '0)) begin
         for (int n = 0; n < NUM_SRC; n++) begin
            if (id_src_i[n*REG_AW +: REG_AW] == ex_dest_i) begin
               load_use = 1'b1;
            end
         end
      end
   end

   // Freeze while a load in EX/MEM waits on memory; freeze masks the stall.
   always_comb begin
      freeze_o = tags[0].valid && tags[0].is_load && !mem_ready_i;
      stall_o  = load_use && !freeze_o;
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q,  stall_cnt_d;
   logic [31:0] freeze_cnt_q, freeze_cnt_d;

   // Saturating increments of the event counters.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      freeze_cnt_d = freeze_cnt_q;
      if (stall_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (freeze_o && (freeze_cnt_q != '1)) begin
         freeze_cnt_d = freeze_cnt_q + 32'd1;
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         freeze_cnt_q <= freeze_cnt_d;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with an expected-result queue.
module tb_hazard_forward_unit;

   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 2;
   localparam int SEL_W   = 2;

   logic                      clk = 1'b0;
   logic                      reset_i;
   logic                      ex_reg_write_i;
   logic                      ex_mem_read_i;
   logic [REG_AW-1:0]         ex_dest_i;
   logic [NUM_SRC*REG_AW-1:0] ex_src_i;
   logic                      id_valid_i;
   logic [NUM_SRC*REG_AW-1:0] id_src_i;
   logic                      mem_ready_i;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
   logic                      stall_o;
   logic                      freeze_o;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]               stall_cnt_o;
   logic [31:0]               freeze_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string                    tag;
      logic [NUM_SRC*SEL_W-1:0] sel;
      logic                     stall;
      logic                     freeze;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   hazard_forward_unit #(
      .REG_AW         (REG_AW),
      .NUM_SRC        (NUM_SRC),
      .DEPTH          (DEPTH)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .ex_reg_write_i (ex_reg_write_i),
      .ex_mem_read_i  (ex_mem_read_i),
      .ex_dest_i      (ex_dest_i),
      .ex_src_i       (ex_src_i),
      .id_valid_i     (id_valid_i),
      .id_src_i       (id_src_i),
      .mem_ready_i    (mem_ready_i),
      .fwd_sel_o      (fwd_sel_o),
      .stall_o        (stall_o),
`ifdef HAZ_PERF_CNT_EN
      .stall_cnt_o    (stall_cnt_o),
      .freeze_cnt_o   (freeze_cnt_o),
`endif
      .freeze_o       (freeze_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected for it.
   task automatic drive(input string tag, input logic rst,
                        input logic wr, input logic ld, input int dest,
                        input int es1, input int es0,
                        input logic idv, input int is1, input int is0,
                        input logic rdy,
                        input int sel1, input int sel0,
                        input logic stl, input logic frz);
      exp_t e;
      reset_i        = rst;
      ex_reg_write_i = wr;
      ex_mem_read_i  = ld;
      ex_dest_i      = REG_AW'(dest);
      ex_src_i       = {REG_AW'(es1), REG_AW'(es0)};
      id_valid_i     = idv;
      id_src_i       = {REG_AW'(is1), REG_AW'(is0)};
      mem_ready_i    = rdy;
      e.tag    = tag;
      e.sel    = {SEL_W'(sel1), SEL_W'(sel0)};
      e.stall  = stl;
      e.freeze = frz;
      sb_q.push_back(e);
   endtask

   // Sample outputs on the falling edge, compare against the queue, then advance.
   task automatic sample_and_step();
      exp_t e;
      @(negedge clk);
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb_q.pop_front();
         chk({e.tag, ".sel"},    32'(fwd_sel_o), 32'(e.sel));
         chk({e.tag, ".stall"},  32'(stall_o),   32'(e.stall));
         chk({e.tag, ".freeze"}, 32'(freeze_o),  32'(e.freeze));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic rst,
                       input logic wr, input logic ld, input int dest,
                       input int es1, input int es0,
                       input logic idv, input int is1, input int is0,
                       input logic rdy,
                       input int sel1, input int sel0,
                       input logic stl, input logic frz);
      drive(tag, rst, wr, ld, dest, es1, es0, idv, is1, is0, rdy, sel1, sel0, stl, frz);
      sample_and_step();
   endtask

   initial begin
      reset_i = 1'b1; ex_reg_write_i = 1'b0; ex_mem_read_i = 1'b0; ex_dest_i = '0;
      ex_src_i = '0; id_valid_i = 1'b0; id_src_i = '0; mem_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      //    tag          rst wr ld dst es1 es0 idv is1 is0 rdy  sel1 sel0 stl frz
      step("reset_state", 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,   0,   0,   0,  0);
`ifdef HAZ_PERF_CNT_EN
      chk("cnt_reset_stall",  stall_cnt_o,  32'd0);
      chk("cnt_reset_freeze", freeze_cnt_o, 32'd0);
`endif
      step("wr_r5",       0, 1, 0, 5,  0,  0,  0,  0,  0,  1,   0,   0,   0,  0);
      step("fwd_e1",      0, 0, 0, 0,  0,  5,  0,  0,  0,  1,   0,   1,   0,  0);
      step("fwd_e2",      0, 0, 0, 0,  0,  5,  0,  0,  0,  1,   0,   2,   0,  0);
      step("fwd_gone",    0, 0, 0, 0,  0,  5,  0,  0,  0,  1,   0,   0,   0,  0);
      step("wr_r7_a",     0, 1, 0, 7,  7,  0,  0,  0,  0,  1,   0,   0,   0,  0);
      step("wr_r7_b",     0, 1, 0, 7,  7,  0,  0,  0,  0,  1,   1,   0,   0,  0);
      step("youngest",    0, 0, 0, 0,  7,  7,  0,  0,  0,  1,   1,   1,   0,  0);
      step("wr_r0",       0, 1, 0, 0,  0,  7,  0,  0,  0,  1,   0,   2,   0,  0);
      step("r0_nofwd",    0, 0, 0, 0,  0,  0,  0,  0,  0,  1,   0,   0,   0,  0);
      step("load_use",    0, 1, 1, 3,  0,  0,  1,  0,  3,  1,   0,   0,   1,  0);
      step("bubble",      0, 0, 0, 0,  0,  0,  1,  0,  3,  1,   0,   0,   0,  0);
      step("load_r0",     0, 1, 1, 0,  0,  0,  1,  0,  0,  1,   0,   0,   0,  0);
      step("load_r4",     0, 1, 1, 4,  0,  0,  0,  0,  0,  1,   0,   0,   0,  0);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("freeze%0d", i),
                          0, 1, 1, 6,  0,  4,  1,  0,  6,  0,   0,   1,   0,  1);
      end
      step("thaw",        0, 1, 1, 6,  0,  4,  1,  0,  6,  1,   0,   1,   1,  0);
      step("post_thaw",   0, 0, 0, 0,  6,  4,  0,  0,  0,  1,   1,   2,   0,  0);
      step("load_r9",     0, 1, 1, 9,  0,  0,  0,  0,  0,  1,   0,   0,   0,  0);
`ifdef HAZ_PERF_CNT_EN
      chk("cnt_stall",  stall_cnt_o,  32'd2);
      chk("cnt_freeze", freeze_cnt_o, 32'd3);
`endif
      step("rst_in_frz",  1, 0, 0, 0,  0,  9,  0,  0,  0,  0,   0,   1,   0,  1);
      step("after_rst",   0, 0, 0, 0,  0,  9,  0,  0,  0,  0,   0,   0,   0,  0);
`ifdef HAZ_PERF_CNT_EN
      chk("cnt_clr_stall",  stall_cnt_o,  32'd0);
      chk("cnt_clr_freeze", freeze_cnt_o, 32'd0);
`endif

      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction (channels).
REQ-003 SHALL have parameter DEPTH, default 2, legal 1..4, number of tracked post-EX stages (stage 1 = EX/MEM, stage 2 = MEM/WB, ...).
REQ-004 SHALL derive localparam SEL_W = $clog2(DEPTH+1).
REQ-005 clk_i  in  1  single clock; one clock, all state updates on rising edge.
REQ-006 reset_i  in  1  reset is synchronous and active-high.
REQ-007 ex_reg_write_i  in  1  instruction currently in EX writes a register.
REQ-008 ex_mem_read_i  in  1  instruction in EX is a load.
REQ-009 ex_dest_i  in  REG_AW  destination register of instruction in EX.
REQ-010 ex_src_i  in  NUM_SRC*REG_AW  source registers of instruction in EX, channel n at bits [n*REG_AW +: REG_AW].
REQ-011 id_valid_i  in  1  valid instruction in ID.
REQ-012 id_src_i  in  NUM_SRC*REG_AW  source registers of instruction in ID.
REQ-013 mem_ready_i  in  1  data memory returns load data this cycle.
REQ-014 fwd_sel_o  out  NUM_SRC*SEL_W  per-channel operand select: 0 = register file, k = result of stage k.
REQ-015 stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-016 freeze_o  out  1  hold every pipeline register.

Function
REQ-017 SHALL keep a tag pipe of DEPTH entries {valid, dest, is_load}; on each edge with freeze_o=0, entry 1 <= {ex_reg_write_i && ex_dest_i!=0, ex_dest_i, ex_mem_read_i}, entry k <= entry k-1.
REQ-018 SHALL hold all tag entries unchanged while freeze_o=1.
REQ-019 fwd_sel_o channel n SHALL be the lowest k with entry k valid and dest == ex_src channel n, else 0 (combinational from tags; zero-cycle latency).
REQ-020 Register 0 SHALL never be forwarded or cause a stall.
REQ-021 stall_o SHALL be 1 when id_valid_i, ex_mem_read_i, ex_reg_write_i, ex_dest_i!=0 and any id_src channel equals ex_dest_i (load-use); 0 otherwise.
REQ-022 freeze_o SHALL be 1 when entry 1 is valid with is_load=1 and mem_ready_i=0; it SHALL fall the cycle mem_ready_i rises.
REQ-023 When freeze_o=1, stall_o SHALL be forced to 0 (freeze dominates).
REQ-024 A stall cycle SHALL not alter the tag pipe beyond normal REQ-017 shifting; the bubble appears as ex_reg_write_i=0 the next cycle.
REQ-025 Simultaneous matches in several stages SHALL resolve to the youngest (lowest k).

Reset
REQ-026 While reset_i=1 at an edge, all tag entries SHALL clear to invalid; fwd_sel_o=0, stall_o=0 (unless REQ-021 holds combinationally), freeze_o=0 next cycle.
REQ-027 Reset asserted mid-freeze SHALL drop freeze_o the cycle after the reset edge.

Configuration
REQ-028 With HAZ_PERF_CNT_EN defined, SHALL add outputs stall_cnt_o and freeze_cnt_o (32 bit), incremented each cycle stall_o/freeze_o is 1, saturating at 2^32-1, cleared by reset.
REQ-029 Without HAZ_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold the tag entry typedef and the select encoding constants (SEL_RF = 0).
REQ-031 A sub-module hazard_tag_pipe SHALL implement the freezable tag shift register; match/priority logic stays in the top.

Verification
REQ-032 ex: write r5, next cycle ex_src ch0=r5 -> fwd_sel ch0=1; one cycle later match only in entry 2 -> 2.
REQ-033 entries 1 and 2 both dest r7, ex_src ch1=r7 -> fwd_sel ch1=1.
REQ-034 ex load r3, id_src ch0=r3, id_valid=1 -> stall_o=1 one cycle; with r0 instead -> stall_o=0.
REQ-035 load in entry 1, mem_ready_i=0 for 3 cycles -> freeze_o=1 for exactly 3 cycles, tags unchanged, stall_o=0.
REQ-036 reset_i=1 during freeze -> freeze_o=0, fwd_sel=0 next cycle; with HAZ_PERF_CNT_EN counters read 0.
